// File: rtl/hex_stream_pkg.sv
// Shared definitions for the hex word streamer.
//   state_t      : frame sequencing states
//   ASCII_*      : fixed characters emitted around the hex digits
package hex_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX0,
    S_PREFIX1,
    S_DIGIT,
    S_CR,
    S_LF
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/hex_word_streamer_to_ascii.sv
// Nibble to ASCII hex digit decoder (uppercase A-F).
//   nibble : 4-bit value
//   ascii  : 8-bit character '0'..'9', 'A'..'F'
module to_ascii
  import hex_stream_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else begin
      ascii = ASCII_A + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_word_streamer.sv
// Prints one binary word as a stream of ASCII hex characters, MSB nibble
// first, with an optional "0x" prefix and optional CR/LF terminator.
//   clk, rst              : clock, synchronous active-high reset
//   word_valid/word_data  : word offered by upstream
//   word_ready            : high only while idle
//   tx_valid/tx_data      : character to downstream (tx_data=00 when invalid)
//   tx_ready              : downstream accepts the character this cycle
//   busy                  : frame in progress
module hex_word_streamer
  import hex_stream_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int PREFIX_0X   = 0,
  parameter int APPEND_CRLF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int DIGITS = WORD_W / 4;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  digit_cnt;
  logic [7:0]        digit_ascii;
  logic              xfer;

  to_ascii u_to_ascii (
    .nibble (shreg[WORD_W-1 -: 4]),
    .ascii  (digit_ascii)
  );

  // Outputs depend only on registered state, so tx_ready/word_* never
  // reach tx_valid/tx_data combinationally and data holds during stalls.
  assign tx_valid   = (state != S_IDLE);
  assign word_ready = (state == S_IDLE);
  assign busy       = ~word_ready;
  assign xfer       = tx_valid & tx_ready;

  always_comb begin
    tx_data = 8'h00;
    case (state)
      S_PREFIX0: tx_data = ASCII_ZERO;
      S_PREFIX1: tx_data = ASCII_X;
      S_DIGIT:   tx_data = digit_ascii;
      S_CR:      tx_data = ASCII_CR;
      S_LF:      tx_data = ASCII_LF;
      default:   tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      digit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (word_valid) begin
            shreg     <= word_data;
            digit_cnt <= LAST_DIGIT;
            state     <= (PREFIX_0X != 0) ? S_PREFIX0 : S_DIGIT;
          end
        end
        S_PREFIX0: if (xfer) state <= S_PREFIX1;
        S_PREFIX1: if (xfer) state <= S_DIGIT;
        S_DIGIT: begin
          if (xfer) begin
            shreg     <= shreg << 4;
            digit_cnt <= digit_cnt - CNT_W'(1);
            // Last digit leaves the frame body; returning to S_IDLE
            // guarantees at least one idle cycle between frames.
            if (digit_cnt == '0) begin
              state <= (APPEND_CRLF != 0) ? S_CR : S_IDLE;
            end
          end
        end
        S_CR:    if (xfer) state <= S_LF;
        S_LF:    if (xfer) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_streamer.sv
module tb_hex_word_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;

  logic        word_valid16;
  logic [15:0] word_data16;
  logic        word_ready16;
  logic        tx_valid16;
  logic [7:0]  tx_data16;
  logic        tx_ready16;
  logic        busy16;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e6[6];

  always #5 clk = ~clk;

  hex_word_streamer #(.WORD_W(32), .PREFIX_0X(0), .APPEND_CRLF(1)) dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy)
  );

  hex_word_streamer #(.WORD_W(16), .PREFIX_0X(1), .APPEND_CRLF(0)) dut16 (
    .clk(clk), .rst(rst), .word_valid(word_valid16), .word_data(word_data16),
    .word_ready(word_ready16), .tx_valid(tx_valid16), .tx_data(tx_data16),
    .tx_ready(tx_ready16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input string tag, input logic [31:0] w);
    chk({tag, "_ready_before"}, 32'(word_ready), 32'd1);
    word_valid = 1'b1;
    word_data  = w;
    tick();
    word_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    chk({tag, "_valid_after_accept"}, 32'(tx_valid), 32'd1);
  endtask

  // Drains one frame against exp_q; rnd randomises tx_ready.
  task automatic collect(input string tag, input bit rnd, input int exp_busy);
    int idx = 0;
    int busy_cnt = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    while (idx < exp_q.size() && cyc < 400) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (word_ready == 1'b0) busy_cnt++;
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_stall_data"}, 32'(tx_data), 32'(prev_data));
      end
      if (!rnd) chk({tag, "_consecutive_valid"}, 32'(tx_valid), 32'd1);
      if (tx_valid && tx_ready) begin
        chk({tag, "_byte"}, 32'(tx_data), 32'(exp_q[idx]));
        idx++;
      end
      prev_stall = tx_valid & ~tx_ready;
      prev_data  = tx_data;
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    chk({tag, "_byte_count"}, 32'(idx), 32'(exp_q.size()));
    chk({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_idle_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_idle_ready"}, 32'(word_ready), 32'd1);
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    rst = 1'b1;
    word_valid = 1'b0; word_data = '0; tx_ready = 1'b1;
    word_valid16 = 1'b0; word_data16 = '0; tx_ready16 = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_word_ready", 32'(word_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("idle_hold_valid", 32'(tx_valid), 32'd0);

    // 1: DEADBEEF, tx_ready always high
    exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    send_word("t1", 32'hDEADBEEF);
    collect("t1", 1'b0, 10);

    // 2: DEADBEEF, random back-pressure
    tick();
    send_word("t2", 32'hDEADBEEF);
    collect("t2", 1'b1, -1);

    // 3: mixed digits, then all zeros
    tick();
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h46, 8'h0D, 8'h0A};
    send_word("t3a", 32'h0123ABCF);
    collect("t3a", 1'b0, 10);
    tick();
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    send_word("t3b", 32'h00000000);
    collect("t3b", 1'b0, 10);

    // 4: new word held on word_valid during a frame
    tick();
    exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    send_word("t4a", 32'hDEADBEEF);
    word_valid = 1'b1;
    word_data  = 32'h11111111;
    collect("t4a", 1'b0, 10);
    tick();
    word_valid = 1'b0;
    chk("t4b_accepted_busy", 32'(busy), 32'd1);
    exp_q = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
    collect("t4b", 1'b0, 10);

    // 5: reset after the 3rd transfer
    tick();
    send_word("t5", 32'hDEADBEEF);
    tx_ready = 1'b1;
    tick(); tick(); tick();
    chk("t5_fourth_char", 32'(tx_data), 32'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", 32'(tx_valid), 32'd0);
    chk("t5_rst_data", 32'(tx_data), 32'd0);
    chk("t5_rst_ready", 32'(word_ready), 32'd1);
    tick();
    chk("t5_still_idle", 32'(tx_valid), 32'd0);
    exp_q = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    send_word("t5b", 32'hCAFE0000);
    collect("t5b", 1'b0, 10);

    // 6: 16-bit, prefix on, no CR/LF
    e6 = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h46, 8'h46};
    chk("t6_ready_before", 32'(word_ready16), 32'd1);
    word_valid16 = 1'b1;
    word_data16  = 16'h00FF;
    tick();
    word_valid16 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t6_valid", 32'(tx_valid16), 32'd1);
      chk("t6_byte", 32'(tx_data16), 32'(e6[i]));
      tick();
    end
    chk("t6_idle_valid", 32'(tx_valid16), 32'd0);
    chk("t6_idle_ready", 32'(word_ready16), 32'd1);
    chk("t6_idle_busy", 32'(busy16), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
